switch_debouncer: RTL
=====================

// Module: switch_debouncer
//
// PURPOSE
// - Upstream conditioning stage for the LED blinker. Takes raw, bouncy, asynchronous
//   board switches and produces clean, clock-synchronous levels for the blinker's
//   i_switch_1/i_switch_2 inputs.
// - Also produces one-cycle rise/fall strobes for downstream mode logic.
// - Per channel: 2-FF synchroniser, then a stability counter, then a registered output.
//
// PARAMETERS
// - c_NUM_SW          2        number of independent switch channels
// - c_DEBOUNCE_COUNT  500000   cycles input must stay stable before output follows
//                              (10 ms at 50 MHz); legal range >= 2
// - c_CNT_W           32       width of each channel's stability counter;
//                              must hold c_DEBOUNCE_COUNT-1
//
// PORTS
// - i_clk     in   1          system clock, 50 MHz
// - i_rst     in   1          reset, asynchronous, active-high
// - i_switch  in   c_NUM_SW   raw switch levels; asynchronous to i_clk
// - o_switch  out  c_NUM_SW   debounced level per channel
// - o_rise    out  c_NUM_SW   1-cycle pulse when o_switch[n] goes 0->1
// - o_fall    out  c_NUM_SW   1-cycle pulse when o_switch[n] goes 1->0
//
// BEHAVIOUR
// - Reset (i_rst=1, async assert, released on clock edges):
//   - clears all sync FFs, counters, o_switch, o_rise and o_fall to 0.
//   - No pulse is generated by reset assertion or release.
//   - Reset mid-count discards the count.
// - Sync stage: r_sync1[n] <= i_switch[n]; r_sync2[n] <= r_sync1[n].
//   Only r_sync2 is used downstream.
// - Stability counter, evaluated at every posedge for each channel n independently:
//   - r_sync2==o_switch:
//     - cnt <= 0; no pulse.
//   - r_sync2!=o_switch and cnt < c_DEBOUNCE_COUNT-1:
//     - cnt <= cnt+1; no pulse.
//   - r_sync2!=o_switch and cnt == c_DEBOUNCE_COUNT-1:
//     - o_switch <= r_sync2; cnt <= 0.
//     - o_rise <= r_sync2; o_fall <= ~r_sync2.
// - Latency: input changes before edge 0 and is held. r_sync2 updates at edge 1.
//   o_switch updates at edge c_DEBOUNCE_COUNT+1, which is N+2 edges including edge 0.
// - o_rise/o_fall:
//   - Registered, high for exactly one cycle, coincident with the o_switch change.
//   - Default 0 on every other cycle.
//   - Never both high on the same channel.
// - Glitch rejection: any return to the current o_switch value before the count
//   completes clears cnt. There is no partial credit; the next change restarts from 0.
// - Counter never wraps; it saturates by construction at c_DEBOUNCE_COUNT-1
//   and then clears.
// - Channels are fully independent. Simultaneous transitions on several channels
//   update and pulse in the same cycle.
// - Fully synchronous datapath except the async reset. No combinational path
//   from input to output.
//
// TESTING  (bench uses c_DEBOUNCE_COUNT=4, c_NUM_SW=2)
// - Reset: i_rst=1 with i_switch=2'b11 -> o_switch=0, o_rise=0, o_fall=0.
//   Release reset, hold 2'b11 -> o_switch=2'b11 at edge 5 after first sampling
//   edge, o_rise=2'b11 for exactly that one cycle.
// - Clean press: ch0 0->1 held -> o_switch[0] rises at edge 5, o_rise[0] one cycle,
//   o_fall=0. Release held -> o_switch[0] falls 5 edges later, o_fall[0] one cycle.
// - Bounce: ch0 toggles 1,0,1,0 every 2 cycles, then holds 1 -> no output change
//   during bouncing; o_switch[0]=1 exactly 5 edges after last toggle; one o_rise pulse.
// - Short glitch: ch1 high for 3 cycles then low -> o_switch[1] stays 0,
//   no pulses, counter back to 0.
// - Reset mid-count: ch0 high, assert i_rst asynchronously after 3 cycles ->
//   outputs 0 immediately (before next edge). After release, full 5-edge latency
//   restarts.
// - Independence: ch0 rises at cycle 0, ch1 rises at cycle 2 -> pulses at edges 5
//   and 7 respectively. Both rising at once -> o_rise=2'b11 in a single cycle.

Source files
------------

// File: rtl/switch_debouncer.sv
// Debounces raw asynchronous switches: a 2-FF synchroniser, a stability counter and a
// registered level per channel, plus one-cycle rise/fall strobes.

module switch_debouncer_lane #(
    parameter int c_DEBOUNCE_COUNT = 500000,
    parameter int c_CNT_W          = 32
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_switch,
    output logic o_switch,
    output logic o_rise,
    output logic o_fall
);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_DEBOUNCE_COUNT - 1);

    logic               sync1;
    logic               sync2;
    logic [c_CNT_W-1:0] cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            cnt      <= '0;
            o_switch <= 1'b0;
            o_rise   <= 1'b0;
            o_fall   <= 1'b0;
        end else begin
            sync1  <= i_switch;
            sync2  <= sync1;
            o_rise <= 1'b0;
            o_fall <= 1'b0;
            // Any sample matching the current output wipes the accumulated count.
            if (sync2 == o_switch) begin
                cnt <= '0;
            end else if (cnt == c_LAST) begin
                o_switch <= sync2;
                o_rise   <= sync2;
                o_fall   <= ~sync2;
                cnt      <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module switch_debouncer #(
    parameter int c_NUM_SW         = 2,
    parameter int c_DEBOUNCE_COUNT = 500000,
    parameter int c_CNT_W          = 32
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [c_NUM_SW-1:0] i_switch,
    output logic [c_NUM_SW-1:0] o_switch,
    output logic [c_NUM_SW-1:0] o_rise,
    output logic [c_NUM_SW-1:0] o_fall
);
    for (genvar n = 0; n < c_NUM_SW; n++) begin : g_lane
        switch_debouncer_lane #(
            .c_DEBOUNCE_COUNT(c_DEBOUNCE_COUNT),
            .c_CNT_W         (c_CNT_W)
        ) u_lane (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_switch(i_switch[n]),
            .o_switch(o_switch[n]),
            .o_rise  (o_rise[n]),
            .o_fall  (o_fall[n])
        );
    end
endmodule
